// File: rtl/float_copro_ctrl.sv
// Command sequencer for the float coprocessor: dispatches one op at a time to the
// external multiplier or add/sub unit and holds the result. Optional macro: FLOAT_CTRL_MAC_EN.
module float_copro_ctrl #(
    parameter int FW      = 32,
    parameter int MUL_LAT = 2,
    parameter int ADD_LAT = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [FW-1:0] cmd_a,
    input  logic [FW-1:0] cmd_b,
    output logic [FW-1:0] mul_op1,
    output logic [FW-1:0] mul_op2,
    output logic          mul_start,
    input  logic [FW-1:0] mul_res,
    output logic [FW-1:0] add_op1,
    output logic [FW-1:0] add_op2,
    output logic          add_sub,
    output logic          add_start,
    input  logic [FW-1:0] add_res,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [FW-1:0] res_data,
    output logic          res_err,
    output logic          busy
);

    localparam int MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SPC = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
`ifdef FLOAT_CTRL_MAC_EN
        S_MACADD,
        S_MACWAIT,
`endif
        S_HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q;
    logic [FW-1:0]  op_a_q, op_b_q;
    logic           add_sub_q;
    logic [CW-1:0]  cnt_q;
    logic [FW-1:0]  res_data_q;
    logic           res_err_q;
    logic           cmd_fire;
    logic           cnt_zero;
`ifdef FLOAT_CTRL_MAC_EN
    logic [FW-1:0]  acc_q;
    logic           mac_clear;

    assign mac_clear = (cmd_a == '0) && (cmd_b == '0);
`endif

    assign cmd_fire = cmd_valid && cmd_ready;
    assign cnt_zero = (cnt_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        add_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_op == OP_SPC) begin
`ifdef FLOAT_CTRL_MAC_EN
                        state_d = mac_clear ? S_HOLD : S_ISSUE;
`else
                        state_d = S_HOLD;
`endif
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
`ifdef FLOAT_CTRL_MAC_EN
                mul_start = (op_q == OP_MUL) || (op_q == OP_SPC);
`else
                mul_start = (op_q == OP_MUL);
`endif
                add_start = (op_q == OP_ADD) || (op_q == OP_SUB);
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_zero) begin
`ifdef FLOAT_CTRL_MAC_EN
                    state_d = (op_q == OP_SPC) ? S_MACADD : S_HOLD;
`else
                    state_d = S_HOLD;
`endif
                end
            end
`ifdef FLOAT_CTRL_MAC_EN
            S_MACADD: begin
                add_start = 1'b1;
                state_d   = S_MACWAIT;
            end
            S_MACWAIT: begin
                if (cnt_zero) state_d = S_HOLD;
            end
`endif
            S_HOLD: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q       <= OP_MUL;
            op_a_q     <= '0;
            op_b_q     <= '0;
            add_sub_q  <= 1'b0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
`ifdef FLOAT_CTRL_MAC_EN
            acc_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        op_q      <= cmd_op;
                        op_a_q    <= cmd_a;
                        op_b_q    <= cmd_b;
                        add_sub_q <= (cmd_op == OP_SUB);
`ifdef FLOAT_CTRL_MAC_EN
                        if (cmd_op == OP_SPC && mac_clear) begin
                            res_data_q <= '0;
                            res_err_q  <= 1'b0;
                            acc_q      <= '0;
                        end
`else
                        if (cmd_op == OP_SPC) begin
                            res_data_q <= '0;
                            res_err_q  <= 1'b1;
                        end
`endif
                    end
                end
                S_ISSUE: begin
                    // MAC ops start on the multiplier, so they share its latency here.
                    if (op_q == OP_MUL || op_q == OP_SPC) cnt_q <= CW'(MUL_LAT - 1);
                    else                                  cnt_q <= CW'(ADD_LAT - 1);
                end
                S_WAIT: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
`ifdef FLOAT_CTRL_MAC_EN
                    else if (op_q == OP_SPC) begin
                        op_a_q    <= mul_res;
                        op_b_q    <= acc_q;
                        add_sub_q <= 1'b0;
                    end
`endif
                    else begin
                        res_data_q <= (op_q == OP_MUL) ? mul_res : add_res;
                        res_err_q  <= 1'b0;
                    end
                end
`ifdef FLOAT_CTRL_MAC_EN
                S_MACADD: cnt_q <= CW'(ADD_LAT - 1);
                S_MACWAIT: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        res_data_q <= add_res;
                        res_err_q  <= 1'b0;
                        acc_q      <= add_res;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Both units read the same operand registers; only the start pulse selects which one runs.
    assign mul_op1   = op_a_q;
    assign mul_op2   = op_b_q;
    assign add_op1   = op_a_q;
    assign add_op2   = op_b_q;
    assign add_sub   = add_sub_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign res_valid = (state_q == S_HOLD);
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_float_copro_ctrl.sv
// Scoreboard bench for float_copro_ctrl: behavioural float units with exact latency,
// directed commands push expected results, a negedge monitor checks the result port.
module tb_float_copro_ctrl;

    localparam int FW      = 32;
    localparam int MUL_LAT = 2;
    localparam int ADD_LAT = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [FW-1:0] cmd_a, cmd_b;
    logic [FW-1:0] mul_op1, mul_op2, mul_res;
    logic          mul_start;
    logic [FW-1:0] add_op1, add_op2, add_res;
    logic          add_sub, add_start;
    logic          res_valid, res_ready, res_err, busy;
    logic [FW-1:0] res_data;

    float_copro_ctrl #(.FW(FW), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_start(mul_start), .mul_res(mul_res),
        .add_op1(add_op1), .add_op2(add_op2), .add_sub(add_sub), .add_start(add_start),
        .add_res(add_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          nmul;
        int          nadd;
        int          pulse;
        logic        sub;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   last_res_hs = 0;
    int   n_mul = 0, n_add = 0, first_pulse = -1;
    logic last_sub = 1'b0;
    logic was_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Normal float32 <-> real, enough for the exact directed vectors used here.
    function automatic real f2r(input logic [31:0] b);
        logic [10:0] e11;
        if (b[30:23] == 8'd0) return 0.0;
        e11 = 11'(b[30:23]) + 11'd896;
        return $bitstoreal({b[31], e11, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Units present garbage until exactly LAT edges after the start pulse.
    logic [31:0] mul_val, add_val;
    int          mul_pend = 0, add_pend = 0;
    initial begin
        mul_res = 32'hDEAD_BEEF;
        add_res = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (mul_start) begin
            mul_val = r2f(f2r(mul_op1) * f2r(mul_op2));
            if (MUL_LAT == 1) mul_res <= mul_val;
            else begin mul_res <= 32'hDEAD_BEEF; mul_pend <= MUL_LAT - 1; end
        end else if (mul_pend > 0) begin
            mul_pend <= mul_pend - 1;
            if (mul_pend == 1) mul_res <= mul_val;
        end
    end

    always @(posedge clk) begin
        if (add_start) begin
            add_val = add_sub ? r2f(f2r(add_op1) - f2r(add_op2)) : r2f(f2r(add_op1) + f2r(add_op2));
            if (ADD_LAT == 1) add_res <= add_val;
            else begin add_res <= 32'hDEAD_BEEF; add_pend <= ADD_LAT - 1; end
        end else if (add_pend > 0) begin
            add_pend <= add_pend - 1;
            if (add_pend == 1) add_res <= add_val;
        end
    end

    always @(posedge clk) cyc++;

    // Monitor: cycle indices are relative to the handshake edge (cycle 0).
    always @(negedge clk) begin
        if (!reset_n) begin
            was_valid   = 1'b0;
            n_mul       = 0;
            n_add       = 0;
            first_pulse = -1;
        end else begin
            if (cmd_valid && cmd_ready) begin
                accept_cyc  = cyc;
                n_mul       = 0;
                n_add       = 0;
                first_pulse = -1;
            end
            if (mul_start) begin
                n_mul++;
                if (first_pulse < 0) first_pulse = cyc - accept_cyc;
            end
            if (add_start) begin
                n_add++;
                last_sub = add_sub;
                if (first_pulse < 0) first_pulse = cyc - accept_cyc;
            end
            if (res_valid && !was_valid) check("res_expected", 64'(sb.size() != 0), 64'd1);
            if (res_valid && sb.size() != 0) begin
                if (!was_valid) begin
                    check("latency", 64'(cyc - accept_cyc), 64'(sb[0].lat));
                    check("mul_pulses", 64'(n_mul), 64'(sb[0].nmul));
                    check("add_pulses", 64'(n_add), 64'(sb[0].nadd));
                    check("pulse_cycle", 64'(first_pulse), 64'(sb[0].pulse));
                    if (n_add > 0) check("add_sub", 64'(last_sub), 64'(sb[0].sub));
                end
                check("res_data", 64'(res_data), 64'(sb[0].data));
                check("res_err", 64'(res_err), 64'(sb[0].err));
                check("cmd_ready_in_hold", 64'(cmd_ready), 64'd0);
                if (res_ready) begin
                    void'(sb.pop_front());
                    last_res_hs = cyc;
                end
            end
            was_valid = res_valid;
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input exp_t e);
        logic ok = 1'b0;
        if (push) sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        for (int i = 0; i < 200; i++) begin
            ok = cmd_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        check("cmd_accept", 64'(ok), 64'd1);
        cmd_valid = 1'b0;
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic err, input int lat,
                                input int nm, input int na, input int p, input logic s);
        exp_t e;
        e.data = d; e.err = err; e.lat = lat; e.nmul = nm; e.nadd = na; e.pulse = p; e.sub = s;
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 64'({res_valid, busy, cmd_ready, mul_start, add_start, add_sub, res_err}),
              64'(7'b0010000));
        check({tag, "_data"}, 64'(res_data), 64'd0);
        check({tag, "_ops"}, {mul_op1, add_op2}, 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1.5 * 2.0 = 3.0, then the subtract, add and a signed multiply.
        send(2'b00, 32'h3FC0_0000, 32'h4000_0000, 1, mk(32'h4040_0000, 0, MUL_LAT + 2, 1, 0, 1, 0));
        drain();
        send(2'b10, 32'h4040_0000, 32'h3F80_0000, 1, mk(32'h4000_0000, 0, ADD_LAT + 2, 0, 1, 1, 1));
        drain();
        send(2'b01, 32'h3F80_0000, 32'h4000_0000, 1, mk(32'h4040_0000, 0, ADD_LAT + 2, 0, 1, 1, 0));
        drain();
        send(2'b00, 32'hC000_0000, 32'h3F00_0000, 1, mk(32'hBF80_0000, 0, MUL_LAT + 2, 1, 0, 1, 0));
        drain();

        // Backpressure: result held 10 cycles while a second command waits.
        res_ready = 1'b0;
        send(2'b00, 32'h4000_0000, 32'h4000_0000, 1, mk(32'h4080_0000, 0, MUL_LAT + 2, 1, 0, 1, 0));
        fork
            send(2'b01, 32'h4000_0000, 32'h4000_0000, 1, mk(32'h4080_0000, 0, ADD_LAT + 2, 0, 1, 1, 0));
            begin
                for (int i = 0; i < 50 && !res_valid; i++) @(posedge clk);
                repeat (10) @(posedge clk);
                #1 res_ready = 1'b1;
            end
        join
        check("accept_after_release", 64'(accept_cyc - last_res_hs), 64'd1);
        drain();

        // Reset in the middle of an add's WAIT window.
        send(2'b01, 32'h3F80_0000, 32'h3F80_0000, 0, mk(32'h0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("abort");
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_pulse", 64'(n_mul + n_add), 64'd0);
        check("abort_no_result", 64'(res_valid), 64'd0);
        send(2'b00, 32'h3FC0_0000, 32'h4000_0000, 1, mk(32'h4040_0000, 0, MUL_LAT + 2, 1, 0, 1, 0));
        drain();

`ifdef FLOAT_CTRL_MAC_EN
        send(2'b11, 32'h0, 32'h0, 1, mk(32'h0, 0, 1, 0, 0, -1, 0));
        drain();
        send(2'b11, 32'h3FC0_0000, 32'h4000_0000, 1,
             mk(32'h4040_0000, 0, MUL_LAT + ADD_LAT + 3, 1, 1, 1, 0));
        drain();
        send(2'b11, 32'h3FC0_0000, 32'h4000_0000, 1,
             mk(32'h40C0_0000, 0, MUL_LAT + ADD_LAT + 3, 1, 1, 1, 0));
        drain();
`else
        send(2'b11, 32'h3FC0_0000, 32'h4000_0000, 1, mk(32'h0, 1, 1, 0, 0, -1, 0));
        drain();
`endif
        // A normal op after the special one still completes cleanly.
        send(2'b10, 32'h3F80_0000, 32'h4000_0000, 1, mk(32'hBF80_0000, 0, ADD_LAT + 2, 0, 1, 1, 1));
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_copro_ctrl.md
Name: float_copro_ctrl

Overview:
- Command sequencer for the float coprocessor.
- Accepts one operation per valid/ready handshake and dispatches operands to the external multiplier or add/sub unit.
- Waits a fixed, per-unit latency, captures the result, and holds it on a valid/ready result port.
- Sits between the host command interface and the float_pack arithmetic units (float_mul, float_addsub wrappers).

Parameters:
- FW, 1+N_exposant+N_mantisse (from float_pack), float word width.
- MUL_LAT, 2, multiplier latency in cycles from start to result stable (>=1).
- ADD_LAT, 3, add/sub latency in cycles from start to result stable (>=1).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 mul, 01 add, 10 sub, 11 special
- cmd_a  in  FW  operand A
- cmd_b  in  FW  operand B
- mul_op1, mul_op2  out  FW  multiplier operands
- mul_start  out  1  one-cycle multiplier start pulse
- mul_res  in  FW  multiplier result
- add_op1, add_op2  out  FW  add/sub operands
- add_sub  out  1  1 = subtract
- add_start  out  1  one-cycle add/sub start pulse
- add_res  in  FW  add/sub result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  FW  result word
- res_err  out  1  result flagged illegal
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n=0 at posedge) values: state IDLE; cmd_ready=1 (after reset release); res_valid=0, res_data=0, res_err=0, busy=0; mul_start=add_start=0; operand regs=0, add_sub=0; counter=0.
- Reset mid-operation aborts the operation; no result is produced and no start pulse is issued afterwards.
- States: IDLE, ISSUE, WAIT, HOLD.
- cmd_ready = (state==IDLE); combinational from state only.
- IDLE: on cmd_valid&cmd_ready, register cmd_op/cmd_a/cmd_b into operand regs (both units' operand outputs driven from these regs), set add_sub=(cmd_op==10), go ISSUE.
- ISSUE (1 cycle): assert mul_start if op 00; add_start if op 01/10. Load counter with unit LAT-1. Go WAIT.
- WAIT: decrement counter each cycle; at counter==0, capture mul_res or add_res into res_data, res_err=0. Go HOLD.
- HOLD: res_valid=1; res_data/res_err stable until res_valid&res_ready; then return to IDLE (res_valid=0 next cycle).
- Latency: handshake edge = cycle 0; ISSUE = cycle 1; WAIT = cycles 2..LAT+1; res_valid high from cycle LAT+2.
- Throughput: one op per LAT+3 cycles minimum when res_ready is held high.
- Op 11 without the optional feature: skip ISSUE/WAIT, go directly to HOLD with res_data=0, res_err=1 (res_valid at cycle 1).
- Operand regs hold their values after issue; units see stable inputs for the whole latency window.
- cmd_valid while not ready: ignored; the command must be held by the host.
- Counter width: clog2(max(MUL_LAT,ADD_LAT))+1 bits; no wrap; LAT=1 means a single WAIT cycle.

Optional Feature:
- Macro: FLOAT_CTRL_MAC_EN.
- Defined: internal FW-bit accumulator acc (reset 0). Op 11 = multiply-accumulate:
  - ISSUE mul on (a,b); wait MUL_LAT.
  - Drive add_op1=mul_res, add_op2=acc, add_sub=0 via extra states MACADD, MACWAIT; add_start pulses once; wait ADD_LAT.
  - Capture into res_data and acc; res_err=0.
  - Latency MUL_LAT+ADD_LAT+3.
  - Op 11 with cmd_a==0 and cmd_b==0 clears acc (result 0, res_err=0, same HOLD path, no unit started).
- Undefined: no acc, no extra states; op 11 is illegal as specified above.

Test Plan:
- Reset, then mul a=0x3FC00000 (1.5), b=0x40000000 (2.0), FW=32, res_ready=1 -> mul_start one cycle at cycle 1; res_valid at cycle 4; res_data=0x40400000 (3.0); res_err=0.
- Sub a=0x40400000 (3.0), b=0x3F800000 (1.0) -> add_sub=1, add_start at cycle 1; res_valid at cycle 5; res_data=0x40000000.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> res_data stable; cmd_ready=0; a second cmd_valid is not accepted; accepted 1 cycle after res_ready=1 handshake.
- Reset mid-WAIT of an add -> outputs at reset values next cycle; no res_valid; next mul completes normally.
- Op 11, macro off -> res_valid at cycle 1, res_err=1, res_data=0, no start pulses.
- Macro on: op11 clear, then op11 (1.5,2.0) twice -> results 0x40400000 then 0x40C00000 (6.0); each latency MUL_LAT+ADD_LAT+3.
